// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter sharing one Avalon-MM SDRAM controller slave.
// Read responses are routed back to their issuer through a small ID FIFO.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_PEND = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,

  input  logic [ADDR_W-1:0] r0_address,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  input  logic [BE_W-1:0]   r0_byteenable,
  output logic              r0_waitrequest,
  output logic              r0_readdatavalid,

  input  logic [ADDR_W-1:0] r1_address,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  input  logic [BE_W-1:0]   r1_byteenable,
  output logic              r1_waitrequest,
  output logic              r1_readdatavalid,

  output logic [DATA_W-1:0] rd_readdata,

  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [BE_W-1:0]   m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,

  output logic              err_orphan
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ARB_OPEN,
    ARB_HELD
  } arb_state_t;

  arb_state_t state, state_nx;

  logic                last;
  logic                held_sel;
  logic                sel;
  logic                sel_valid;
  logic                sel_rd;
  logic                sel_wr;
  logic                fifo_full;
  logic                elig0;
  logic                elig1;
  logic                accept;
  logic                push;
  logic                pop;
  logic                head_id;

  logic [MAX_PEND-1:0] id_mem;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  // Blocking uses the registered count, so a same-cycle pop never frees a slot early.
  assign fifo_full = (count == CNT_W'(MAX_PEND));
  assign elig0     = (r0_read | r0_write) & ~(r0_read & fifo_full);
  assign elig1     = (r1_read | r1_write) & ~(r1_read & fifo_full);

  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    state_nx  = ARB_OPEN;
    case (state)
      ARB_HELD: begin
        sel       = held_sel;
        sel_valid = held_sel ? elig1 : elig0;
      end
      default: begin
        if (elig0 & elig1) begin
          sel = ~last;
        end else begin
          sel = elig1;
        end
        sel_valid = elig0 | elig1;
      end
    endcase
    if (sel_valid & m_waitrequest) begin
      state_nx = ARB_HELD;
    end
  end

  // A port asserting both read and write is treated as reading.
  assign sel_rd       = sel ? r1_read  : r0_read;
  assign sel_wr       = sel ? r1_write : r0_write;
  assign m_address    = sel ? r1_address    : r0_address;
  assign m_writedata  = sel ? r1_writedata  : r0_writedata;
  assign m_byteenable = sel ? r1_byteenable : r0_byteenable;
  assign m_read       = sel_valid & sel_rd;
  assign m_write      = sel_valid & sel_wr & ~sel_rd;

  assign r0_waitrequest = (sel_valid & ~sel) ? m_waitrequest : 1'b1;
  assign r1_waitrequest = (sel_valid &  sel) ? m_waitrequest : 1'b1;

  assign accept  = sel_valid & ~m_waitrequest;
  assign push    = accept & m_read;
  assign pop     = m_readdatavalid & (count != '0);
  assign head_id = id_mem[rd_ptr];

  assign rd_readdata      = m_readdata;
  assign r0_readdatavalid = pop & ~head_id;
  assign r1_readdatavalid = pop &  head_id;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= ARB_OPEN;
      held_sel <= 1'b0;
      last     <= 1'b1;
    end else begin
      state <= state_nx;
      if (sel_valid & m_waitrequest) begin
        held_sel <= sel;
      end
      if (accept) begin
        last <= sel;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= sel;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      err_orphan <= 1'b0;
    end else if (m_readdatavalid & (count == '0)) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized and directed bench for sdram_port_arbiter against a queue-based
// behavioural model of the arbitration and response-routing rules.
module tb_sdram_port_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int BE_W     = 2;
  localparam int MAX_PEND = 4;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [ADDR_W-1:0] r0_address, r1_address;
  logic              r0_read, r0_write, r1_read, r1_write;
  logic [DATA_W-1:0] r0_writedata, r1_writedata;
  logic [BE_W-1:0]   r0_byteenable, r1_byteenable;
  logic              r0_waitrequest, r0_readdatavalid;
  logic              r1_waitrequest, r1_readdatavalid;
  logic [DATA_W-1:0] rd_readdata;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              err_orphan;

  always #5 clk_clk = ~clk_clk;

  sdram_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .BE_W    (BE_W),
    .MAX_PEND(MAX_PEND)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .r0_address      (r0_address),
    .r0_read         (r0_read),
    .r0_write        (r0_write),
    .r0_writedata    (r0_writedata),
    .r0_byteenable   (r0_byteenable),
    .r0_waitrequest  (r0_waitrequest),
    .r0_readdatavalid(r0_readdatavalid),
    .r1_address      (r1_address),
    .r1_read         (r1_read),
    .r1_write        (r1_write),
    .r1_writedata    (r1_writedata),
    .r1_byteenable   (r1_byteenable),
    .r1_waitrequest  (r1_waitrequest),
    .r1_readdatavalid(r1_readdatavalid),
    .rd_readdata     (rd_readdata),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .err_orphan      (err_orphan)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of issuer IDs for outstanding reads plus arbitration history.
  int q[$];
  bit md_last, md_locked, md_held, md_err;
  bit stall[2];

  task automatic model_reset();
    q.delete();
    md_last   = 1'b1;
    md_locked = 1'b0;
    md_held   = 1'b0;
    md_err    = 1'b0;
    stall[0]  = 1'b0;
    stall[1]  = 1'b0;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    #1;
    reset_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_inputs();
    r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
    r0_address = '0; r1_address = '0;
    r0_writedata = '0; r1_writedata = '0;
    r0_byteenable = '1; r1_byteenable = '1;
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
  endtask

  // Called right after a rising edge with inputs driven; compares, advances model, waits an edge.
  task automatic step();
    bit rd[2], wr[2], e[2], ew[2];
    bit full, v, s, has, head;
    logic [ADDR_W-1:0] ad[2];
    logic [DATA_W-1:0] wd[2];
    logic [BE_W-1:0]   be[2];
    #2;
    rd[0] = r0_read;  wr[0] = r0_write;  ad[0] = r0_address; wd[0] = r0_writedata; be[0] = r0_byteenable;
    rd[1] = r1_read;  wr[1] = r1_write;  ad[1] = r1_address; wd[1] = r1_writedata; be[1] = r1_byteenable;
    full = (q.size() == MAX_PEND);
    for (int i = 0; i < 2; i++) e[i] = (rd[i] || wr[i]) && !(rd[i] && full);
    if (md_locked) begin
      s = md_held; v = e[s];
    end else if (e[0] && e[1]) begin
      s = !md_last; v = 1'b1;
    end else begin
      s = e[1]; v = e[0] || e[1];
    end
    for (int i = 0; i < 2; i++) ew[i] = (v && s == i) ? m_waitrequest : 1'b1;
    has  = (q.size() > 0);
    head = has ? q[0][0] : 1'b0;

    check("m_read", m_read, v && rd[s]);
    check("m_write", m_write, v && wr[s] && !rd[s]);
    if (v) begin
      check("m_address", m_address, ad[s]);
      check("m_writedata", m_writedata, wd[s]);
      check("m_byteenable", m_byteenable, be[s]);
    end
    check("r0_waitrequest", r0_waitrequest, ew[0]);
    check("r1_waitrequest", r1_waitrequest, ew[1]);
    check("r0_readdatavalid", r0_readdatavalid, m_readdatavalid && has && !head);
    check("r1_readdatavalid", r1_readdatavalid, m_readdatavalid && has && head);
    check("rd_readdata", rd_readdata, m_readdata);
    check("err_orphan", err_orphan, md_err);

    if (m_readdatavalid && !has) md_err = 1'b1;
    if (m_readdatavalid && has) void'(q.pop_front());
    if (v && !m_waitrequest) begin
      md_last = s;
      if (rd[s]) q.push_back(int'(s));
    end
    md_locked = v && m_waitrequest;
    if (md_locked) md_held = s;
    for (int i = 0; i < 2; i++) stall[i] = (rd[i] || wr[i]) && ew[i];
    @(posedge clk_clk);
    #1;
  endtask

  task automatic gen_port(output logic rd, output logic wr, output logic [ADDR_W-1:0] a,
                          output logic [DATA_W-1:0] d, output logic [BE_W-1:0] b);
    int k;
    rd = 0; wr = 0;
    if ($urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, 19);
      if (k == 0) begin rd = 1; wr = 1; end
      else if (k < 10) rd = 1;
      else wr = 1;
    end
    a = ADDR_W'($urandom());
    d = DATA_W'($urandom());
    b = BE_W'($urandom());
  endtask

  task automatic rand_drive();
    if (!stall[0]) gen_port(r0_read, r0_write, r0_address, r0_writedata, r0_byteenable);
    if (!stall[1]) gen_port(r1_read, r1_write, r1_address, r1_writedata, r1_byteenable);
    m_waitrequest   = ($urandom_range(0, 9) < 3);
    m_readdatavalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
    m_readdata      = DATA_W'($urandom());
  endtask

  logic [DATA_W-1:0] rdat[3];

  initial begin
    idle_inputs();
    model_reset();
    reset_reset_n = 1'b0;

    // Reset with a read already pending on port 0.
    @(posedge clk_clk); #1;
    r0_read = 1; r0_address = 25'h0ABCDE;
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    model_reset();
    #1;
    check("rst_err_orphan", err_orphan, 0);
    check("rst_m_read", m_read, 1);
    check("rst_m_address", m_address, 25'h0ABCDE);
    check("rst_r1_wait", r1_waitrequest, 1);
    step();

    // Continuous write contention alternates grants starting with port 0.
    idle_inputs(); do_reset();
    r0_write = 1; r1_write = 1;
    for (int i = 0; i < 6; i++) begin
      r0_address = ADDR_W'(32'h100 + i); r0_writedata = DATA_W'(32'h1000 + i);
      r1_address = ADDR_W'(32'h200 + i); r1_writedata = DATA_W'(32'h2000 + i);
      #1;
      check("cont_addr", m_address, (i % 2 == 0) ? 32'h100 + i : 32'h200 + i);
      check("cont_data", m_writedata, (i % 2 == 0) ? 32'h1000 + i : 32'h2000 + i);
      step();
    end

    // Stalled port 1 write holds the bus while port 0 waits.
    idle_inputs(); do_reset();
    r1_write = 1; r1_address = 25'h0001234; m_waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin r0_write = 1; r0_address = 25'h55; end
      #1;
      check("lock_addr", m_address, 25'h0001234);
      check("lock_r0_wait", r0_waitrequest, 1);
      step();
    end
    m_waitrequest = 0;
    #1;
    check("lock_rel_addr", m_address, 25'h0001234);
    check("lock_rel_r1_wait", r1_waitrequest, 0);
    step();
    r1_write = 0;
    #1;
    check("lock_next_addr", m_address, 25'h55);
    check("lock_next_r0_wait", r0_waitrequest, 0);
    step();

    // Read responses return to their issuers in order.
    idle_inputs(); do_reset();
    r0_read = 1; r0_address = 25'h10; step();
    r0_read = 0; r1_read = 1; r1_address = 25'h20; step();
    r1_read = 0; r0_read = 1; r0_address = 25'h30; step();
    r0_read = 0;
    rdat[0] = 16'hAAAA; rdat[1] = 16'hBBBB; rdat[2] = 16'hCCCC;
    for (int i = 0; i < 3; i++) begin
      m_readdatavalid = 1; m_readdata = rdat[i];
      #1;
      check("route_rdv0", r0_readdatavalid, (i != 1));
      check("route_rdv1", r1_readdatavalid, (i == 1));
      check("route_data", rd_readdata, rdat[i]);
      step();
      m_readdatavalid = 0;
      repeat (2) step();
    end

    // Full FIFO: reads blocked, writes pass, registered count keeps the block during a pop.
    idle_inputs(); do_reset();
    r0_read = 1;
    for (int i = 0; i < MAX_PEND; i++) begin
      r0_address = ADDR_W'(32'h40 + i);
      step();
    end
    r1_write = 1; r1_address = 25'h77;
    #1;
    check("full_m_write", m_write, 1);
    check("full_r0_wait", r0_waitrequest, 1);
    check("full_r1_wait", r1_waitrequest, 0);
    step();
    r1_write = 0; m_readdatavalid = 1;
    #1;
    check("full_pop_r0_wait", r0_waitrequest, 1);
    check("full_pop_m_read", m_read, 0);
    step();
    m_readdatavalid = 0;
    #1;
    check("full_after_m_read", m_read, 1);
    check("full_after_r0_wait", r0_waitrequest, 0);
    step();

    // Orphan response sets a sticky error cleared only by reset.
    idle_inputs(); do_reset();
    m_readdatavalid = 1;
    #1;
    check("orph_rdv0", r0_readdatavalid, 0);
    check("orph_rdv1", r1_readdatavalid, 0);
    step();
    m_readdatavalid = 0;
    check("orph_err", err_orphan, 1);
    repeat (3) step();
    check("orph_sticky", err_orphan, 1);
    do_reset();
    #1;
    check("orph_cleared", err_orphan, 0);
    step();

    // A read in flight across reset comes back as an orphan.
    r0_read = 1; r0_address = 25'h99; step();
    r0_read = 0; do_reset(); step();
    m_readdatavalid = 1; m_readdata = 16'h1357; step();
    m_readdatavalid = 0; step();

    // Randomized traffic with Avalon hold behaviour on stalled requesters.
    idle_inputs(); do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single SDRAM controller Avalon-MM slave (16-bit, 64 MB).
- Lets the Nios/HPS-bridge path (port 0) and a streaming DMA/display path (port 1) share the controller.
- Forwards one command per cycle with zero added latency.
- Tracks outstanding pipelined reads in an ID FIFO so each readdatavalid is routed back to the requester that issued it.

Parameters:
- ADDR_W, 25, word address width to the controller
- DATA_W, 16, data width
- BE_W, 2, byteenable width (DATA_W/8)
- MAX_PEND, 4, max outstanding reads; ID FIFO depth, power of two, ≥2

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- r0_address  in  ADDR_W  requester 0 address (likewise r1_*)
- r0_read  in  1  requester 0 read request
- r0_write  in  1  requester 0 write request
- r0_writedata  in  DATA_W  requester 0 write data
- r0_byteenable  in  BE_W  requester 0 byte enables
- r0_waitrequest  out  1  stall to requester 0
- r0_readdatavalid  out  1  read data valid for requester 0
- r1_address, r1_read, r1_write, r1_writedata, r1_byteenable, r1_waitrequest, r1_readdatavalid  (same as r0_*)
- rd_readdata  out  DATA_W  read data shared by both requesters; qualified by rN_readdatavalid
- m_address  out  ADDR_W  to controller
- m_read  out  1  to controller
- m_write  out  1  to controller
- m_writedata  out  DATA_W  to controller
- m_byteenable  out  BE_W  to controller
- m_waitrequest  in  1  from controller
- m_readdata  in  DATA_W  from controller
- m_readdatavalid  in  1  from controller
- err_orphan  out  1  sticky: readdatavalid arrived with no read outstanding

Behaviour:
- Clock and reset:
  - Single clock domain (clk_clk); reset_reset_n is asynchronous, active-low.
  - Reset values: last=1 (port 0 wins the first tie), locked=0, FIFO empty, err_orphan=0.
  - Combinational outputs follow the reset-state registers.
- Request definition: reqN = rN_read | rN_write. read and write both high on the same port is illegal and treated as a read.
- Selection (combinational each cycle):
  - If locked, sel = held_sel.
  - Else if both ports request, sel = ~last.
  - Else sel is the single requesting port.
  - If neither requests, no command is issued.
- Read blocking: a read is blocked when fifo_count == MAX_PEND. A blocked read is not eligible, so the other port's write may win. Writes are never blocked by the FIFO.
- Forwarding:
  - m_* = selected port's signals; m_read/m_write are 0 when there is no eligible selection.
  - Selected port: rN_waitrequest = m_waitrequest.
  - Non-selected or ineligible requesting port: rN_waitrequest = 1. An idle port also sees 1.
- Accept: accept = (m_read | m_write) & ~m_waitrequest.
  - On accept: last <= sel, locked <= 0.
  - If the accepted command is a read, push sel into the FIFO.
- Lock: command presented with m_waitrequest=1 -> locked <= 1, held_sel <= sel. Selection is held until accepted, per Avalon hold rules. No preemption.
- Response routing:
  - rd_readdata = m_readdata, always.
  - On m_readdatavalid with FIFO non-empty: pop the head, assert rN_readdatavalid for the head ID in the same cycle (combinational).
  - On m_readdatavalid with FIFO empty: both rN_readdatavalid = 0, err_orphan <= 1 (cleared only by reset).
- Simultaneous push and pop: count unchanged, both take effect. When full with a pop this cycle, a new read is still blocked: the block uses the registered count.
- Pointers: wrap modulo MAX_PEND; count is $clog2(MAX_PEND)+1 bits.
- Throughput: back-to-back accepts every cycle. Alternating ports under continuous contention gives 50/50 service.
- Reset mid-transfer: all state clears immediately. In-flight responses after reset are orphans and set err_orphan.

Test Plan:
- Reset: reset_reset_n=0 with r0_read=1, release -> err_orphan=0, FIFO empty. First cycle: m_read=1, m_address=r0_address, r1_waitrequest=1.
- Contention, m_waitrequest=0, both ports writing continuously for 6 cycles -> grants 0,1,0,1,0,1; each write appears on m_* in the same cycle, unchanged.
- Lock: r1 write 0x0001234 presented, m_waitrequest=1 for 3 cycles while r0 also requests -> m_address stays 0x0001234 all 3 cycles, r0_waitrequest=1. Release -> r1 accepted, r0 granted the next cycle.
- Routing: reads r0@0x10, r1@0x20, r0@0x30 accepted, then 3 readdatavalid pulses (data 0xAAAA, 0xBBBB, 0xCCCC) with 2-cycle gaps -> r0_readdatavalid, r1_readdatavalid, r0_readdatavalid in order, each with the matching rd_readdata.
- Full: MAX_PEND=4 reads outstanding, r0 read plus r1 write pending -> r1 write accepted, r0_waitrequest=1. One readdatavalid -> r0 read issued the following cycle.
- Orphan: m_readdatavalid=1 with FIFO empty -> no rN_readdatavalid. err_orphan=1 from the next cycle and stays 1 until reset.
